pc_unit: RTL and testbench

//   Program counter register plus next-PC selection for the single-cycle MIPS core.

---
 rtl/pc_if.sv | 30 +++
 rtl/pc_unit.sv | 79 +++++++
 tb/tb_pc_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_if.sv
// Bundle between the single-cycle core control/datapath and the PC unit.
// Use the slave modport on the PC unit and the master modport on the driving core logic.
interface pc_if #(
   parameter int CNT_W = 32
);
   logic             stall;
   logic             branch;
   logic             branch_ne;
   logic             zero;
   logic             jump;
   logic             jr;
   logic [15:0]      imm16;
   logic [25:0]      target26;
   logic [31:0]      rs_data;
   logic [31:0]      pc;
   logic [31:0]      pc_plus4;
   logic             halted;
   logic             misalign;
   logic [CNT_W-1:0] instr_cnt;

   modport master (
      output stall, branch, branch_ne, zero, jump, jr, imm16, target26, rs_data,
      input  pc, pc_plus4, halted, misalign, instr_cnt
   );

   modport slave (
      input  stall, branch, branch_ne, zero, jump, jr, imm16, target26, rs_data,
      output pc, pc_plus4, halted, misalign, instr_cnt
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter with next-PC selection, self-loop halt detection and a retired-instruction count.
// The pc output addresses instruction fetch; a halt freezes everything until reset.
//
// state  | meaning
// S_RUN  | fetching, PC advances every unstalled cycle
// S_HALT | self-loop seen, PC and count frozen until rst
module pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input logic clk,
   input logic rst,
   pc_if.slave bus
);
   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             misalign_q, misalign_d;

   logic [31:0] pc_plus4;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] jr_tgt;
   logic [31:0] next_pc;
   logic        taken;
   logic        advance;

   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      taken    = bus.branch & (bus.branch_ne ? ~bus.zero : bus.zero);
      br_tgt   = pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
      j_tgt    = {pc_plus4[31:28], bus.target26, 2'b00};
      jr_tgt   = {bus.rs_data[31:2], 2'b00};
      if (bus.jr)        next_pc = jr_tgt;
      else if (bus.jump) next_pc = j_tgt;
      else if (taken)    next_pc = br_tgt;
      else               next_pc = pc_plus4;
      advance  = (state_q == S_RUN) && !bus.stall;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RUN;
         pc_q       <= RESET_PC;
         cnt_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (advance && (next_pc == pc_q)) state_d = S_HALT;
   end

   // The self-loop instruction itself still retires; only later cycles are frozen.
   always_comb begin
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      misalign_d = misalign_q;
      if (advance) begin
         pc_d  = next_pc;
         cnt_d = cnt_q + CNT_W'(1);
         if (bus.jr && (bus.rs_data[1:0] != 2'b00)) misalign_d = 1'b1;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.pc_plus4  = pc_plus4;
   assign bus.halted    = (state_q == S_HALT);
   assign bus.misalign  = misalign_q;
   assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded bench for pc_unit: directed scenarios followed by random control traffic.
module tb_pc_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_if #(.CNT_W(32)) bus ();
   pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic        halted;
      logic        misalign;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;

   // reference state
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_cnt = 32'h0;
   logic        m_halt = 1'b0;
   logic        m_mis = 1'b0;

   // stimulus for the upcoming edge
   logic        s_rst, s_stall, s_branch, s_bne, s_zero, s_jump, s_jr;
   logic [15:0] s_imm;
   logic [25:0] s_t26;
   logic [31:0] s_rs;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      s_rst = 0; s_stall = 0; s_branch = 0; s_bne = 0; s_zero = 0;
      s_jump = 0; s_jr = 0; s_imm = 16'h0; s_t26 = 26'h0; s_rs = 32'h0;
   endtask

   // Reference: what the architecture says one retired instruction does.
   task automatic model_step();
      logic [31:0] nxt;
      logic [31:0] seq;
      int          off;
      bit          take;
      exp_t        e;
      if (s_rst) begin
         m_pc = 32'h0; m_cnt = 0; m_halt = 0; m_mis = 0;
      end else if (!m_halt && !s_stall) begin
         seq  = m_pc + 32'd4;
         take = s_branch && ((s_bne && !s_zero) || (!s_bne && s_zero));
         off  = $signed(s_imm);
         if (s_jr) begin
            nxt = s_rs - (s_rs % 4);
            if (s_rs % 4 != 0) m_mis = 1;
         end else if (s_jump) nxt = (seq & 32'hF000_0000) | (32'(s_t26) * 4);
         else if (take)       nxt = seq + 32'(off * 4);
         else                 nxt = seq;
         if (nxt == m_pc) m_halt = 1;
         m_pc  = nxt;
         m_cnt = m_cnt + 1;
      end
      e.pc = m_pc; e.pc_plus4 = m_pc + 32'd4; e.halted = m_halt;
      e.misalign = m_mis; e.cnt = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(negedge clk);
      rst           = s_rst;
      bus.stall     = s_stall;
      bus.branch    = s_branch;
      bus.branch_ne = s_bne;
      bus.zero      = s_zero;
      bus.jump      = s_jump;
      bus.jr        = s_jr;
      bus.imm16     = s_imm;
      bus.target26  = s_t26;
      bus.rs_data   = s_rs;
      model_step();
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // monitor: every edge consumes the prediction pushed for it
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_pc",        bus.pc,              e.pc);
         chk("sb_pc_plus4",  bus.pc_plus4,        e.pc_plus4);
         chk("sb_halted",    32'(bus.halted),     32'(e.halted));
         chk("sb_misalign",  32'(bus.misalign),   32'(e.misalign));
         chk("sb_instr_cnt", bus.instr_cnt,       e.cnt);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      bus.stall = 0; bus.branch = 0; bus.branch_ne = 0; bus.zero = 0; bus.jump = 0;
      bus.jr = 0; bus.imm16 = 0; bus.target26 = 0; bus.rs_data = 0;

      // 1: reset then sequential fetch
      idle(); s_rst = 1; step(); step();
      settle();
      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_cnt", bus.instr_cnt, 32'h0);
      idle();
      for (int i = 0; i < 4; i++) step();
      settle();
      chk("seq_pc", bus.pc, 32'h10);
      chk("seq_cnt", bus.instr_cnt, 32'd4);
      chk("seq_halted", 32'(bus.halted), 32'h0);

      // 2: beq taken backwards, then not taken
      idle(); s_branch = 1; s_zero = 1; s_imm = 16'hFFFE; step();
      settle();
      chk("beq_taken", bus.pc, 32'h0C);
      idle(); s_jump = 1; s_t26 = 26'h4; step();
      idle(); s_branch = 1; s_zero = 0; s_imm = 16'hFFFE; step();
      settle();
      chk("beq_not_taken", bus.pc, 32'h14);

      // 3: jump keeps the upper nibble of pc+4
      idle(); s_jr = 1; s_rs = 32'h3000_0040; step();
      settle();
      chk("jr_aligned_pc", bus.pc, 32'h3000_0040);
      chk("pc_plus4", bus.pc_plus4, 32'h3000_0044);
      idle(); s_jump = 1; s_t26 = 26'h0000100; step();
      settle();
      chk("jump_tgt", bus.pc, 32'h3000_0400);

      // 4: misaligned jr target, flag sticky
      idle(); s_jr = 1; s_jump = 1; s_t26 = 26'h3FF; s_rs = 32'h0000_0123; step();
      settle();
      chk("jr_mis_pc", bus.pc, 32'h0000_0120);
      chk("jr_mis_flag", 32'(bus.misalign), 32'h1);
      idle(); step(); step();
      settle();
      chk("mis_sticky", 32'(bus.misalign), 32'h1);

      // 5: self-loop halt, inputs ignored, reset exits
      idle(); s_jump = 1; s_t26 = 26'h8; step();
      idle(); s_branch = 1; s_zero = 1; s_imm = 16'hFFFF; step();
      idle(); step();
      settle();
      chk("halt_pc", bus.pc, 32'h20);
      chk("halt_flag", 32'(bus.halted), 32'h1);
      for (int i = 0; i < 4; i++) begin
         idle(); s_jump = i[0]; s_stall = i[1]; s_t26 = 26'h123; step();
      end
      settle();
      chk("halt_frozen_pc", bus.pc, 32'h20);
      idle(); s_rst = 1; step();
      settle();
      chk("halt_rst_pc", bus.pc, 32'h0);
      chk("halt_rst_flag", 32'(bus.halted), 32'h0);
      chk("halt_rst_cnt", bus.instr_cnt, 32'h0);
      chk("rst_clears_mis", 32'(bus.misalign), 32'h0);

      // 6: stalled jump, then release; reset mid-stall
      idle(); step(); step();
      for (int i = 0; i < 3; i++) begin
         idle(); s_stall = 1; s_jump = 1; s_t26 = 26'h40; step();
      end
      settle();
      chk("stall_hold_pc", bus.pc, 32'h8);
      chk("stall_hold_cnt", bus.instr_cnt, 32'd2);
      idle(); s_jump = 1; s_t26 = 26'h40; step();
      settle();
      chk("unstall_jump", bus.pc, 32'h100);
      chk("unstall_cnt", bus.instr_cnt, 32'd3);
      idle(); s_stall = 1; s_jump = 1; step();
      idle(); s_stall = 1; s_jump = 1; s_rst = 1; step();
      settle();
      chk("rst_mid_stall", bus.pc, 32'h0);

      // random traffic against the reference
      for (int n = 0; n < 3000; n++) begin
         idle();
         s_rst    = ($urandom_range(0, 39) == 0);
         s_stall  = ($urandom_range(0, 3) == 0);
         s_branch = ($urandom_range(0, 2) == 0);
         s_bne    = $urandom_range(0, 1);
         s_zero   = $urandom_range(0, 1);
         s_jump   = ($urandom_range(0, 5) == 0);
         s_jr     = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       s_imm = 16'hFFFF;
            1:       s_imm = 16'($urandom_range(0, 8)) - 16'd4;
            default: s_imm = 16'($urandom);
         endcase
         s_t26 = 26'($urandom);
         s_rs  = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : $urandom;
         step();
      end
      settle();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
